// File: rtl/text_packet_tx_pkg.sv
// Shared constants, frame FSM encoding and length clamp for the text packet transmitter.
package text_packet_tx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam logic [7:0] TYPE_TEXT = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        TYPE,
        LEN,
        PAYLOAD,
        CSUM
    } frame_state_t;

    function automatic logic [7:0] clamp_len(input logic [7:0] size, input logic [7:0] cap);
        return (size > cap) ? cap : size;
    endfunction

endpackage

// File: rtl/text_packet_tx_if.sv
// Byte stream handshake between the frame sequencer and the UART serialiser.
interface text_packet_tx_if;

    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; ready rises in the final stop-bit cycle so the next
// byte's start bit follows with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic             i_clk,
    input  logic             i_rst,
    text_packet_tx_if.slave  s_byte,
    output logic             o_tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic             r_active;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [3:0]       r_bit_idx;
    logic [8:0]       r_shift;
    logic             r_tx;
    logic             w_bit_end;
    logic             w_last;
    logic             w_load;

    assign w_bit_end    = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last       = r_active && w_bit_end && (r_bit_idx == 4'd9);
    assign s_byte.ready = !r_active || w_last;
    assign w_load       = s_byte.valid && s_byte.ready;
    assign o_tx         = r_tx;

    // Bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active  <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_idx <= 4'd0;
            r_tx      <= 1'b1;
        end else if (w_load) begin
            r_active  <= 1'b1;
            r_clk_cnt <= '0;
            r_bit_idx <= 4'd0;
            r_tx      <= 1'b0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_clk_cnt <= '0;
                if (r_bit_idx == 4'd9) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                    r_tx      <= r_shift[0];
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + CNT_W'(1);
            end
        end
    end

    // Shifter holds data then the stop bit; it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            r_shift <= {1'b1, s_byte.data};
        end else if (r_active && w_bit_end && (r_bit_idx != 4'd9)) begin
            r_shift <= {1'b1, r_shift[8:1]};
        end
    end

endmodule

// File: rtl/text_packet_tx.sv
// Framed text transmitter: sends SYNC, TYPE, LEN, payload and an XOR checksum
// back-to-back through the 8N1 byte serialiser.
module text_packet_tx
    import text_packet_tx_pkg::*;
#(
    parameter int CLOCK_HZ = 12000000,
    parameter int BAUD     = 115200,
    parameter int MAX_TEXT = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [MAX_TEXT*8-1:0] text_bytes,
    input  logic [7:0]            text_size,
    input  logic                  text_send,
    output logic                  busy,
    output logic                  done,
    output logic                  TX
);

    localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
    localparam int IDX_W        = (MAX_TEXT > 1) ? $clog2(MAX_TEXT) : 1;

    frame_state_t             r_state;
    frame_state_t             w_state_next;
    logic [MAX_TEXT-1:0][7:0] r_bytes;
    logic [7:0]               r_len;
    logic [7:0]               r_csum;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_done;
    logic [IDX_W-1:0]         w_idx_next;
    logic [IDX_W-1:0]         w_idx_inc;
    logic [7:0]               w_len_in;
    logic [7:0]               w_data;
    logic [7:0]               w_cur_byte;
    logic [7:0]               w_next_byte;
    logic                     w_valid;
    logic                     w_ready;
    logic                     w_accept;
    logic                     w_fold;
    logic                     w_done_next;
    logic                     w_last_payload;

    text_packet_tx_if u_byte_if ();

    assign u_byte_if.valid = w_valid;
    assign u_byte_if.data  = w_data;
    assign w_ready         = u_byte_if.ready;

    assign w_len_in       = clamp_len(text_size, 8'(MAX_TEXT));
    assign w_idx_inc      = r_idx + IDX_W'(1);
    assign w_cur_byte     = r_bytes[r_idx];
    assign w_next_byte    = r_bytes[w_idx_inc];
    assign w_last_payload = (8'(r_idx) == (r_len - 8'd1));

    // r_state names the byte on the wire; the following byte is offered
    // throughout and taken when the serialiser signals byte-complete.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_valid      = 1'b0;
        w_data       = 8'h00;
        w_accept     = 1'b0;
        w_fold       = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_valid = text_send;
                w_data  = SYNC_BYTE;
                if (text_send && w_ready) begin
                    w_accept     = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = SYNC;
                end
            end
            SYNC: begin
                w_valid = 1'b1;
                w_data  = TYPE_TEXT;
                if (w_ready) w_state_next = TYPE;
            end
            TYPE: begin
                w_valid = 1'b1;
                w_data  = r_len;
                if (w_ready) w_state_next = LEN;
            end
            LEN: begin
                w_valid = 1'b1;
                if (r_len == 8'd0) begin
                    w_data = r_csum;
                    if (w_ready) w_state_next = CSUM;
                end else begin
                    w_data = w_cur_byte;
                    w_fold = w_ready;
                    if (w_ready) w_state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                w_valid = 1'b1;
                if (w_last_payload) begin
                    w_data = r_csum;
                    if (w_ready) w_state_next = CSUM;
                end else begin
                    w_data = w_next_byte;
                    w_fold = w_ready;
                    if (w_ready) w_idx_next = w_idx_inc;
                end
            end
            CSUM: begin
                if (w_ready) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Checksum starts as TYPE^LEN and folds in each payload byte as it is handed over.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_len   <= 8'h00;
            r_csum  <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_done  <= w_done_next;
            if (w_accept) begin
                r_len  <= w_len_in;
                r_csum <= TYPE_TEXT ^ w_len_in;
            end else if (w_fold) begin
                r_csum <= r_csum ^ w_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) r_bytes <= text_bytes;
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .i_clk  (CLK),
        .i_rst  (RST),
        .s_byte (u_byte_if),
        .o_tx   (TX)
    );

endmodule

// File: tb/tb_text_packet_tx.sv
// Directed bench for text_packet_tx: decodes TX at bit centres and checks frames, timing and reset.
module tb_text_packet_tx;

    localparam int MAX_TEXT = 32;
    localparam int CPB      = 104;
    localparam int BYTE_CYC = 10 * CPB;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [MAX_TEXT*8-1:0] text_bytes;
    logic [7:0]            text_size;
    logic                  text_send;
    logic                  busy;
    logic                  done;
    logic                  tx;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         busy_cnt;
    int         done_cnt;
    int         frame_err;

    text_packet_tx #(
        .CLOCK_HZ (12000000),
        .BAUD     (115200),
        .MAX_TEXT (MAX_TEXT)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .text_bytes (text_bytes),
        .text_size  (text_size),
        .text_send  (text_send),
        .busy       (busy),
        .done       (done),
        .TX         (tx)
    );

    always #5 clk = ~clk;

    task automatic pulse_send(input logic [7:0] size);
        text_size = size;
        text_send = 1'b1;
        @(negedge clk);
        text_send = 1'b0;
    endtask

    // Entered at the negedge of the first start-bit cycle; leaves at the negedge after the frame.
    task automatic capture_frame(input int nbytes);
        logic [9:0] sh;
        int         phase;
        sh        = '1;
        phase     = 0;
        busy_cnt  = 0;
        done_cnt  = 0;
        frame_err = 0;
        rx_q.delete();
        for (int c = 0; c < nbytes * BYTE_CYC; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if ((c % CPB) == CPB / 2) begin
                sh = {tx, sh[9:1]};
                phase++;
                if (phase == 10) begin
                    if (sh[0] !== 1'b0 || sh[9] !== 1'b1) frame_err++;
                    rx_q.push_back(sh[8:1]);
                    phase = 0;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        text_send  = 1'b1;
        text_size  = 8'd3;
        text_bytes = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL reset_state tx=%b busy=%b done=%b, required 1/0/0", tx, busy, done);
        end
        rst       = 1'b0;
        text_send = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_bad++; $display("FAIL reset_drop busy=%b tx=%b, required 0/1", busy, tx);
        end
    endtask

    task automatic test_hi;
        text_bytes       = '0;
        text_bytes[23:0] = 24'h216948;
        exp_q = '{8'hAA, 8'h03, 8'h03, 8'h48, 8'h69, 8'h21, 8'h00};
        pulse_send(8'd3);
        n_cmp++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            n_bad++; $display("FAIL hi_start busy=%b tx=%b, required 1/0", busy, tx);
        end
        capture_frame(exp_q.size());
        n_cmp++;
        if (busy_cnt !== 7280) begin n_bad++; $display("FAIL hi_busy_len got %0d required 7280", busy_cnt); end
        n_cmp++;
        if (frame_err !== 0) begin n_bad++; $display("FAIL hi_framing got %0d bad bytes required 0", frame_err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL hi_byte%0d got %h required %h", i, rx_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b1 || done_cnt !== 0) begin
            n_bad++; $display("FAIL hi_end busy=%b done=%b early_done=%0d, required 0/1/0", busy, done, done_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL hi_done_width done=%b required 0", done); end
    endtask

    task automatic test_empty;
        text_bytes = {MAX_TEXT{8'h77}};
        exp_q = '{8'hAA, 8'h03, 8'h00, 8'h03};
        pulse_send(8'd0);
        capture_frame(exp_q.size());
        n_cmp++;
        if (busy_cnt !== 4 * BYTE_CYC) begin n_bad++; $display("FAIL empty_busy_len got %0d required %0d", busy_cnt, 4 * BYTE_CYC); end
        n_cmp++;
        if (frame_err !== 0) begin n_bad++; $display("FAIL empty_framing got %0d required 0", frame_err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL empty_byte%0d got %h required %h", i, rx_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL empty_done done=%b busy=%b required 1/0", done, busy); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL empty_done_width done=%b required 0", done); end
    endtask

    task automatic test_clamp;
        text_bytes = {MAX_TEXT{8'h55}};
        exp_q = '{8'hAA, 8'h03, 8'h20};
        for (int i = 0; i < 32; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'h23);
        pulse_send(8'd40);
        capture_frame(exp_q.size());
        n_cmp++;
        if (busy_cnt !== 36 * BYTE_CYC) begin n_bad++; $display("FAIL clamp_busy_len got %0d required %0d", busy_cnt, 36 * BYTE_CYC); end
        n_cmp++;
        if (frame_err !== 0) begin n_bad++; $display("FAIL clamp_framing got %0d required 0", frame_err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL clamp_byte%0d got %h required %h", i, rx_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL clamp_done done=%b busy=%b required 1/0", done, busy); end
        @(negedge clk);
    endtask

    task automatic test_ignore_resend;
        int late_busy;
        text_bytes       = '0;
        text_bytes[23:0] = 24'h216948;
        exp_q = '{8'hAA, 8'h03, 8'h03, 8'h48, 8'h69, 8'h21, 8'h00};
        pulse_send(8'd3);
        fork
            capture_frame(exp_q.size());
            begin
                repeat (2000) @(negedge clk);
                text_bytes = {MAX_TEXT{8'hEE}};
                text_size  = 8'd5;
                text_send  = 1'b1;
                @(negedge clk);
                text_send = 1'b0;
            end
        join
        n_cmp++;
        if (busy_cnt !== 7280) begin n_bad++; $display("FAIL resend_busy_len got %0d required 7280", busy_cnt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL resend_byte%0d got %h required %h", i, rx_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL resend_done done=%b required 1", done); end
        late_busy = 0;
        repeat (2 * BYTE_CYC) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) late_busy++;
        end
        n_cmp++;
        if (late_busy !== 0) begin n_bad++; $display("FAIL resend_second_frame active_cycles=%0d required 0", late_busy); end
    endtask

    task automatic test_reset_midframe;
        int pre_busy;
        text_bytes       = '0;
        text_bytes[23:0] = 24'h216948;
        pulse_send(8'd3);
        pre_busy = 0;
        repeat (4 * BYTE_CYC + 500) begin
            if (busy !== 1'b1) pre_busy++;
            @(negedge clk);
        end
        n_cmp++;
        if (pre_busy !== 0) begin n_bad++; $display("FAIL abort_prebusy idle_cycles=%0d required 0", pre_busy); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL abort_state tx=%b busy=%b done=%b, required 1/0/0", tx, busy, done);
        end
        rst      = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        repeat (2 * BYTE_CYC) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b0 || tx !== 1'b1) busy_cnt++;
        end
        n_cmp++;
        if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_no_done pulses=%0d required 0", done_cnt); end
        n_cmp++;
        if (busy_cnt !== 0) begin n_bad++; $display("FAIL abort_idle active_cycles=%0d required 0", busy_cnt); end
        text_bytes      = '0;
        text_bytes[7:0] = 8'h5A;
        exp_q = '{8'hAA, 8'h03, 8'h01, 8'h5A, 8'h58};
        pulse_send(8'd1);
        capture_frame(exp_q.size());
        n_cmp++;
        if (busy_cnt !== 5 * BYTE_CYC) begin n_bad++; $display("FAIL abort_next_len got %0d required %0d", busy_cnt, 5 * BYTE_CYC); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL abort_next_byte%0d got %h required %h", i, rx_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL abort_next_done done=%b required 1", done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_q = '{8'hAA, 8'h03, 8'h00, 8'h03};
        pulse_send(8'd0);
        capture_frame(exp_q.size());
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_first_done done=%b busy=%b required 1/0", done, busy); end
        text_size = 8'd0;
        text_send = 1'b1;
        @(negedge clk);
        text_send = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || tx !== 1'b0) begin n_bad++; $display("FAIL b2b_start busy=%b tx=%b required 1/0", busy, tx); end
        capture_frame(exp_q.size());
        n_cmp++;
        if (busy_cnt !== 4 * BYTE_CYC || frame_err !== 0) begin
            n_bad++; $display("FAIL b2b_second_len busy=%0d framing=%0d required %0d/0", busy_cnt, frame_err, 4 * BYTE_CYC);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_byte%0d got %h required %h", i, rx_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_second_done done=%b busy=%b required 1/0", done, busy); end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        text_send  = 1'b0;
        text_size  = 8'd0;
        text_bytes = '0;
        @(negedge clk);
        test_reset();
        test_hi();
        test_empty();
        test_clamp();
        test_ignore_resend();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
